// File: rtl/replica_pkg.sv
// replica_pkg: shared move types, array sizing and scheduler states for the annealing replica array
package replica_pkg;
    localparam int base_log = 5;
    localparam int city_num = 32;
    localparam int city_log = $clog2(city_num);
    typedef enum logic [1:0] {SWAP = 2'd0, REV = 2'd1, THR = 2'd2, NOP = 2'd3} com_t;
    typedef struct packed {
        com_t                com;
        logic [city_log-1:0] a;
        logic [city_log-1:0] b;
    } opt_t;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, NEXT, FINISH} sched_state_t;
endpackage

// File: rtl/seed_table.sv
// seed_table: per-replica 64-bit seed register file, one write port and one async read port
module seed_table #(
    parameter int DEPTH = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/opt_sched.sv
// opt_sched: time-shares one xorshift move generator across all replicas, sweep by sweep
module opt_sched
    import replica_pkg::*;
#(
    parameter int REP_NUM = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [31:0]         iter_num,
    output logic                busy,
    output logic                done,
    output logic [31:0]         sweep_cnt,
    output logic                parity,
    output logic                err_timeout,
    input  logic                seed_we,
    input  logic [base_log-1:0] seed_addr,
    input  logic [63:0]         seed_wdata,
    output logic                gen_run,
    output logic [base_log-1:0] gen_base_id,
    output logic [63:0]         gen_seed,
    input  logic                gen_ready,
    input  logic [63:0]         gen_n_seed,
    input  opt_t                gen_opt,
    output logic                opt_valid,
    input  logic                opt_ready,
    output opt_t                opt_out
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [base_log-1:0] LAST = base_log'(REP_NUM - 1);

    sched_state_t        state;
    logic [CW-1:0]       wcnt;
    logic [31:0]         iter_lat;
    logic                cap;
    logic                tab_we;
    logic [base_log-1:0] tab_addr;
    logic [63:0]         tab_wdata;

    // ready is stale for the first two WAIT cycles; the generator only clears it after seeing run
    assign cap       = state == WAIT && wcnt >= CW'(2) && gen_ready;
    assign tab_we    = cap || (state == IDLE && seed_we);
    assign tab_addr  = cap ? gen_base_id : seed_addr;
    assign tab_wdata = cap ? gen_n_seed : seed_wdata;

    seed_table #(.DEPTH(REP_NUM), .AW(base_log)) u_tab (
        .clk   (clk),
        .we    (tab_we),
        .waddr (tab_addr),
        .wdata (tab_wdata),
        .raddr (gen_base_id),
        .rdata (gen_seed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            gen_run     <= 1'b0;
            opt_valid   <= 1'b0;
            err_timeout <= 1'b0;
            parity      <= 1'b0;
            sweep_cnt   <= '0;
            gen_base_id <= '0;
            opt_out     <= '{com: THR, a: '0, b: '0};
            wcnt        <= '0;
            iter_lat    <= '0;
        end else begin
            done    <= 1'b0;
            gen_run <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    done        <= iter_num == 32'd0;
                    err_timeout <= 1'b0;
                    if (iter_num != 32'd0) begin
                        iter_lat    <= iter_num;
                        sweep_cnt   <= '0;
                        parity      <= 1'b0;
                        gen_base_id <= '0;
                        busy        <= 1'b1;
                        gen_run     <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: if (cap) begin
                    opt_out   <= gen_opt;
                    opt_valid <= 1'b1;
                    state     <= SEND;
                end else if (wcnt == CW'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= FINISH;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                SEND: if (opt_ready) begin
                    opt_valid <= 1'b0;
                    state     <= NEXT;
                end
                NEXT: begin
                    if (gen_base_id == LAST) begin
                        sweep_cnt   <= sweep_cnt + 32'd1;
                        parity      <= ~parity;
                        gen_base_id <= '0;
                    end else if (!stop) begin
                        gen_base_id <= gen_base_id + 1'b1;
                    end
                    if (stop || (gen_base_id == LAST && sweep_cnt + 32'd1 == iter_lat)) begin
                        state <= FINISH;
                    end else begin
                        gen_run <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_opt_sched.sv
// tb_opt_sched: scoreboard bench with a behavioural xorshift generator and a replica-side sink
`timescale 1ns/1ps
module tb_opt_sched;
    import replica_pkg::*;
    localparam int REP = 32;
    localparam int TMO = 16;
    localparam int OW = $bits(opt_t);

    typedef struct packed {
        logic [base_log-1:0] id;
        opt_t                opt;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic [31:0]         iter_num = '0;
    logic                busy, done, parity, err_timeout;
    logic [31:0]         sweep_cnt;
    logic                seed_we = 1'b0;
    logic [base_log-1:0] seed_addr = '0;
    logic [63:0]         seed_wdata = '0;
    logic                gen_run;
    logic [base_log-1:0] gen_base_id;
    logic [63:0]         gen_seed;
    logic                gen_ready;
    logic [63:0]         gen_n_seed;
    opt_t                gen_opt;
    logic                opt_valid;
    logic                opt_ready = 1'b1;
    opt_t                opt_out;

    int n_tests = 0, n_fail = 0;
    int n_run, n_xfer, n_done, cyc = 0, run_cyc = 0, bp_cnt = 0, g_cnt = 0, g_lat = 1;
    logic g_pend = 1'b0, g_stall = 1'b0, bp = 1'b0, zero_run = 1'b0;
    logic [63:0] g_seed = '0, nx, nx_m;
    logic [63:0] mtab [REP];
    logic [base_log-1:0] m_id = '0, last_xfer_id = '0;
    exp_t q[$];
    exp_t e;
    opt_t p_opt, rst_opt;
    logic p_valid = 1'b0, p_busy = 1'b0;
    logic [31:0] p_sc = '0;

    opt_sched #(.REP_NUM(REP), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .iter_num(iter_num),
        .busy(busy), .done(done), .sweep_cnt(sweep_cnt), .parity(parity), .err_timeout(err_timeout),
        .seed_we(seed_we), .seed_addr(seed_addr), .seed_wdata(seed_wdata),
        .gen_run(gen_run), .gen_base_id(gen_base_id), .gen_seed(gen_seed),
        .gen_ready(gen_ready), .gen_n_seed(gen_n_seed), .gen_opt(gen_opt),
        .opt_valid(opt_valid), .opt_ready(opt_ready), .opt_out(opt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // generator keeps its old ready for one cycle after run, then answers after g_lat cycles
    always @(posedge clk) begin
        if (reset) begin
            gen_ready  <= 1'b0;
            gen_n_seed <= '0;
            gen_opt    <= '0;
            g_pend     <= 1'b0;
        end else if (gen_run) begin
            g_pend <= 1'b1;
            g_cnt  <= 0;
            g_seed <= gen_seed;
        end else if (g_pend) begin
            gen_ready <= 1'b0;
            g_cnt     <= g_cnt + 1;
            if (!g_stall && g_cnt + 1 >= g_lat) begin
                nx = xs(g_seed);
                gen_ready  <= 1'b1;
                gen_n_seed <= nx;
                gen_opt    <= opt_t'(nx[OW-1:0]);
                g_pend     <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!bp) opt_ready = 1'b1;
        else if (!opt_valid) begin
            opt_ready = 1'b0;
            bp_cnt = 0;
        end else begin
            bp_cnt++;
            opt_ready = bp_cnt > 5;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (gen_run) begin
                n_run++;
                run_cyc = cyc;
                check("run_id", 64'(gen_base_id), 64'(m_id));
                check("run_seed", gen_seed, mtab[m_id]);
                if (!g_stall) begin
                    nx_m = xs(mtab[m_id]);
                    mtab[m_id] = nx_m;
                    q.push_back('{id: m_id, opt: opt_t'(nx_m[OW-1:0])});
                end
                m_id = m_id + 1'b1;
            end
            if (opt_valid && opt_ready) begin
                n_xfer++;
                last_xfer_id = gen_base_id;
                if (q.size() == 0) check("xfer_unexpected", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    check("xfer_id", 64'(gen_base_id), 64'(e.id));
                    check("xfer_opt", 64'(opt_out), 64'(e.opt));
                end
            end
            if (opt_valid && p_valid) check("bp_hold", 64'(opt_out), 64'(p_opt));
            if (opt_valid) check("run_in_send", 64'(gen_run), 64'd0);
            if (sweep_cnt == p_sc + 32'd1) check("parity", 64'(parity), 64'(sweep_cnt[0]));
            if (done) begin
                n_done++;
                check("busy_at_done", 64'(busy), 64'd0);
                if (!zero_run) check("busy_before_done", 64'(p_busy), 64'd1);
                if (g_stall) begin
                    check("tmo_latency", 64'(cyc - run_cyc), 64'd18);
                    check("tmo_err", 64'(err_timeout), 64'd1);
                end
            end
        end
        p_valid = opt_valid;
        p_opt = opt_out;
        p_busy = busy;
        p_sc = sweep_cnt;
    end

    task automatic start_run(input logic [31:0] iters, input logic we, input logic [base_log-1:0] a,
                             input logic [63:0] d);
        n_run = 0;
        n_xfer = 0;
        n_done = 0;
        m_id = '0;
        @(posedge clk);
        #1;
        start = 1'b1;
        iter_num = iters;
        seed_we = we;
        seed_addr = a;
        seed_wdata = d;
        if (we) mtab[a] = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed_we = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_opt = '{com: THR, a: '0, b: '0};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_run", 64'(gen_run), 64'd0);
        check("rst_valid", 64'(opt_valid), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_parity", 64'(parity), 64'd0);
        check("rst_sweep", 64'(sweep_cnt), 64'd0);
        check("rst_id", 64'(gen_base_id), 64'd0);
        check("rst_opt", 64'(opt_out), 64'(rst_opt));
        for (int k = 0; k < REP; k++) begin
            @(posedge clk);
            #1;
            seed_we = 1'b1;
            seed_addr = base_log'(k);
            seed_wdata = 64'(k + 1);
            mtab[k] = 64'(k + 1);
        end
        @(posedge clk);
        #1;
        seed_we = 1'b0;

        start_run(1, 1'b0, '0, '0);
        wait_done(2000);
        check("t1_runs", 64'(n_run), 64'd32);
        check("t1_xfers", 64'(n_xfer), 64'd32);
        check("t1_sweep", 64'(sweep_cnt), 64'd1);
        check("t1_parity", 64'(parity), 64'd1);
        check("t1_done", 64'(n_done), 64'd1);

        g_lat = 3;
        start_run(3, 1'b0, '0, '0);
        wait_done(5000);
        check("t2_xfers", 64'(n_xfer), 64'd96);
        check("t2_sweep", 64'(sweep_cnt), 64'd3);
        check("t2_parity", 64'(parity), 64'd1);
        check("t2_done", 64'(n_done), 64'd1);

        g_lat = 1;
        bp = 1'b1;
        start_run(1, 1'b0, '0, '0);
        wait_done(5000);
        bp = 1'b0;
        check("t3_xfers", 64'(n_xfer), 64'd32);
        check("t3_done", 64'(n_done), 64'd1);

        g_stall = 1'b1;
        start_run(1, 1'b0, '0, '0);
        wait_done(200);
        g_stall = 1'b0;
        check("t4_err", 64'(err_timeout), 64'd1);
        check("t4_runs", 64'(n_run), 64'd1);
        check("t4_xfers", 64'(n_xfer), 64'd0);
        check("t4_done", 64'(n_done), 64'd1);
        start_run(1, 1'b0, '0, '0);
        wait_done(2000);
        check("t4_err_clr", 64'(err_timeout), 64'd0);
        check("t4_xfers2", 64'(n_xfer), 64'd32);

        start_run(2, 1'b0, '0, '0);
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 500 && !hit; i++) begin
                @(negedge clk);
                hit = gen_run && gen_base_id == base_log'(7);
            end
            check("t5_reach7", 64'(hit), 64'd1);
        end
        @(posedge clk);
        #1;
        stop = 1'b1;
        wait_done(200);
        stop = 1'b0;
        check("t5_runs", 64'(n_run), 64'd8);
        check("t5_xfers", 64'(n_xfer), 64'd8);
        check("t5_last", 64'(last_xfer_id), 64'd7);
        check("t5_sweep", 64'(sweep_cnt), 64'd0);
        check("t5_qempty", 64'(q.size()), 64'd0);
        check("t5_done", 64'(n_done), 64'd1);

        zero_run = 1'b1;
        start_run(0, 1'b0, '0, '0);
        @(negedge clk);
        check("t6_done", 64'(done), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("t6_done_end", 64'(done), 64'd0);
        check("t6_busy_end", 64'(busy), 64'd0);
        zero_run = 1'b0;

        start_run(1, 1'b0, '0, '0);
        repeat (20) @(posedge clk);
        #1;
        seed_we = 1'b1;
        seed_addr = base_log'(3);
        seed_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        #1;
        seed_we = 1'b0;
        wait_done(2000);
        start_run(1, 1'b1, '0, 64'hDEAD_BEEF_0123_4567);
        wait_done(2000);
        check("t7_xfers", 64'(n_xfer), 64'd32);
        check("t7_qempty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/opt_sched.md
Name: opt_sched

Overview:
- Sequences one shared move-proposal generator (xorshift64 random-opt unit) across all replicas of the annealing array.
- Per sweep, visits replica ids 0..REP_NUM-1 in order:
  - hands that replica's stored seed to the generator;
  - writes the advanced seed back;
  - forwards the resulting opt_t to the replica datapath over a valid/ready handshake.
- Counts sweeps, toggles the even/odd exchange parity each sweep, and reports completion or a generator stall.

Parameters:
- REP_NUM, 32, number of replicas; power of two, equal to 2**base_log.
- TIMEOUT, 1024, maximum generator cycles per request before err_timeout is set.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- stop  in  1  level; finish current replica, then terminate early
- iter_num  in  32  sweeps to execute; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- sweep_cnt  out  32  completed sweeps in current/last run
- parity  out  1  exchange parity; toggles at each sweep end
- err_timeout  out  1  sticky generator-stall flag
- seed_we  in  1  host seed-table write; honoured only when idle
- seed_addr  in  base_log  seed-table index
- seed_wdata  in  64  seed value
- gen_run  out  1  one-cycle request pulse to generator
- gen_base_id  out  base_log  replica id for current request
- gen_seed  out  64  seed for current request; stable from gen_run until capture
- gen_ready  in  1  generator result valid (level)
- gen_n_seed  in  64  advanced seed from generator
- gen_opt  in  opt_t  proposed move from generator
- opt_valid  out  1  opt_out valid to replica array
- opt_ready  in  1  replica array accepts opt_out
- opt_out  out  opt_t  registered move for replica gen_base_id

Behaviour:
- Reset values:
  - busy, done, gen_run, opt_valid, err_timeout, parity = 0; sweep_cnt = 0; gen_base_id = 0; opt_out = 0 with com = THR.
  - FSM returns to IDLE from any state. The seed table is not reset.
- Seed table: REP_NUM x 64 registers.
  - Host write takes effect the cycle after seed_we, only in IDLE; ignored otherwise.
  - The FSM reads the table combinationally at gen_base_id.
- FSM states:
  - IDLE:
    - start while iter_num == 0 → done pulse next cycle, stay IDLE, busy stays 0.
    - start with iter_num > 0 → latch iter_num, clear sweep_cnt and parity, set id = 0, busy = 1, go ISSUE.
  - ISSUE: gen_run = 1 for exactly one cycle; gen_seed = table[id]; clear wait counter; go WAIT.
  - WAIT:
    - gen_ready is ignored in the first two cycles after gen_run, because the generator drops stale ready one cycle after run.
    - From the third cycle, gen_ready = 1 → capture gen_opt into opt_out, write gen_n_seed to table[id], go SEND.
    - Wait counter reaching TIMEOUT → err_timeout = 1 and go FINISH; no table write.
  - SEND: opt_valid = 1 until the cycle opt_ready = 1; the transfer occurs on that edge. Then opt_valid = 0, go NEXT.
  - NEXT:
    - id != REP_NUM-1 → id++, go ISSUE, unless stop = 1, which goes FINISH.
    - id == REP_NUM-1 → sweep_cnt++, parity toggles, id = 0.
    - After the increment, sweep_cnt == latched iter_num or stop = 1 → FINISH; else ISSUE.
  - FINISH: busy = 0, done = 1 for one cycle, go IDLE.
- Latency:
  - ISSUE→WAIT = 1 cycle; minimum WAIT = 3 cycles; SEND ≥ 1 cycle; NEXT = 1 cycle.
  - Best case per replica: 6 cycles.
- Simultaneous events:
  - start while busy is ignored.
  - seed_we coincident with an accepted start: the write is applied and the first ISSUE sees it.
  - stop asserted during WAIT/SEND takes effect only at NEXT; the in-flight opt is always delivered.
- err_timeout clears only on reset or on the next accepted start.
- Reset mid-run aborts immediately:
  - no done pulse;
  - seed-table entries written so far are kept.

Decomposition:
- replica_pkg holds:
  - existing opt_t, base_log, city_num, com codes;
  - new sched_state_t enum {IDLE, ISSUE, WAIT, SEND, NEXT, FINISH}.
- One sub-module, seed_table: REP_NUM x 64 register file with one write port (mux of host and FSM writeback) and one async read port.

Test Plan:
- Load seeds table[k] = k+1 for k = 0..31; start, iter_num = 1, opt_ready tied 1, behavioural generator → 32 gen_run pulses with gen_base_id 0..31 in order; each gen_seed == k+1; each table entry equals the xorshift of its seed after run; sweep_cnt = 1, parity = 1, one done.
- iter_num = 3 → 96 opt transfers; parity sequence 1, 0, 1; sweep_cnt = 3; busy falls in the same cycle done rises.
- Backpressure: opt_ready low 5 cycles per transfer → opt_valid held, opt_out stable, no new gen_run until transfer.
- Generator stalled (gen_ready stuck 0), TIMEOUT = 16 → err_timeout = 1 after 16 WAIT cycles, done pulse, table[id] unchanged.
- stop raised while id = 7 in WAIT → opt for id 7 delivered, no gen_run for id 8, done, sweep_cnt = 0.
- start with iter_num = 0 → done next cycle, busy never high; seed_we during a busy run → table unchanged.
